// File: rtl/pwm.sv
// N-channel PWM generator sharing one free-running period counter.
// Every channel is phase-aligned. A new duty setting is taken only at
// the period boundary, so each period is glitch-free.

// One output lane: gate the shared compare result with this lane's enable
// and register it.
module pwm_lane (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_hi,
  output logic o_out
);

  // Output flop; reset clears it at once, with no wait for a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_out <= 1'b0;
    else        o_out <= i_en & i_hi;
  end

endmodule

module pwm #(
  parameter int N = 1,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic [R-1:0] ds,
  output logic [N-1:0] out
);

  logic [R-1:0] r_cnt;   // free-running period counter
  logic [R-1:0] r_dsa;   // duty applied to the current period
  logic         w_wrap;  // last clock of the period
  logic         w_hi;    // high phase of the current period

  assign w_wrap = &r_cnt;
  // The high phase starts at cnt == 0 and is contiguous. dsa == 0 never
  // drives the output high. The largest dsa still leaves one low clock.
  assign w_hi   = r_cnt < r_dsa;

  // Period counter: wraps naturally at 2^R-1 and is cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= r_cnt + R'(1);
  end

  // Capture duty on the wrap edge so mid-period ds changes wait a period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_dsa <= '0;
    else if (w_wrap) r_dsa <= ds;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      pwm_lane u_lane (
        .clk   (clk),
        .reset (reset),
        .i_en  (in[gi]),
        .i_hi  (w_hi),
        .o_out (out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm (N=1, R=4, 16-clock period).
// Inputs change and outputs are sampled on the falling clock edge.
// After release, the edge of phase j of period p yields (j < duty_p).
module tb_pwm;

  logic       clk;
  logic       reset;
  logic [0:0] in;
  logic [3:0] ds;
  logic [0:0] out;

  int total = 0;
  int bad   = 0;

  pwm #(.N(1), .R(4)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .ds    (ds),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and land on the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 1'b1; ds = 4'b1111;
    #1 reset = 1'b0;
    #2;
    total++;
    if (out !== 1'b0) begin bad++; $display("FAIL reset_async out=%b want 0", out); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      total++;
      if (out !== 1'b0 || dut.r_cnt !== 4'd0 || dut.r_dsa !== 4'd0) begin
        bad++;
        $display("FAIL reset_edge out=%b cnt=%0d dsa=%0d want 0/0/0", out, dut.r_cnt, dut.r_dsa);
      end
      @(negedge clk);
      total++;
      if (out !== 1'b0 || dut.r_cnt !== 4'd0 || dut.r_dsa !== 4'd0) begin
        bad++;
        $display("FAIL reset_mid out=%b cnt=%0d dsa=%0d want 0/0/0", out, dut.r_cnt, dut.r_dsa);
      end
    end
    reset = 1'b1;
  endtask

  // 16 low clocks after release, then 15 high / 1 low periods
  task automatic test_full_duty();
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'b0) begin bad++; $display("FAIL full_first j=%0d out=%b want 0", j, out); end
    end
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 16; j++) begin
        tick();
        total++;
        if (out !== 1'(j < 15)) begin
          bad++; $display("FAIL full_duty p=%0d j=%0d out=%b want %b", p, j, out, 1'(j < 15));
        end
      end
  endtask

  // Each new ds is written mid-period. That period keeps the old duty.
  task automatic test_sweep();
    logic [3:0] duties [4];
    logic [3:0] prev;
    duties = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    prev = 4'd15;
    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 16; j++) begin
        tick();
        total++;
        if (out !== 1'(j < prev)) begin
          bad++; $display("FAIL sweep_trans ds=%0d j=%0d out=%b want %b", duties[d], j, out, 1'(j < prev));
        end
        if (j == 5) ds = duties[d];
      end
      for (int p = 0; p < 3; p++)
        for (int j = 0; j < 16; j++) begin
          tick();
          total++;
          if (out !== 1'(j < duties[d])) begin
            bad++; $display("FAIL sweep ds=%0d p=%0d j=%0d out=%b want %b", duties[d], p, j, out, 1'(j < duties[d]));
          end
        end
      prev = duties[d];
    end
  endtask

  task automatic test_zero();
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'(j < 1)) begin bad++; $display("FAIL zero_trans j=%0d out=%b want %b", j, out, 1'(j < 1)); end
      if (j == 5) ds = 4'b0000;
    end
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 16; j++) begin
        tick();
        total++;
        if (out !== 1'b0) begin bad++; $display("FAIL zero p=%0d j=%0d out=%b want 0", p, j, out); end
      end
  endtask

  // in drops after phase 2 and returns after phase 4, so phases 3 and 4 are low
  task automatic test_gating();
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'b0) begin bad++; $display("FAIL gate_trans j=%0d out=%b want 0", j, out); end
      if (j == 5) ds = 4'b1000;
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'(j < 8)) begin bad++; $display("FAIL gate_pre j=%0d out=%b want %b", j, out, 1'(j < 8)); end
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'(j < 8 && j != 3 && j != 4)) begin
        bad++; $display("FAIL gate j=%0d out=%b want %b", j, out, 1'(j < 8 && j != 3 && j != 4));
      end
      if (j == 2) in = 1'b0;
      if (j == 4) in = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    for (int j = 0; j < 4; j++) tick();
    total++;
    if (out !== 1'b1) begin bad++; $display("FAIL mrst_pre out=%b want 1", out); end
    #1 reset = 1'b0;
    #1;
    total++;
    if (out !== 1'b0) begin bad++; $display("FAIL mrst_async out=%b want 0", out); end
    total++;
    if (dut.r_cnt !== 4'd0 || dut.r_dsa !== 4'd0) begin
      bad++; $display("FAIL mrst_state cnt=%0d dsa=%0d want 0/0", dut.r_cnt, dut.r_dsa);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'b0) begin bad++; $display("FAIL mrst_first j=%0d out=%b want 0", j, out); end
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (out !== 1'(j < 8)) begin bad++; $display("FAIL mrst_second j=%0d out=%b want %b", j, out, 1'(j < 8)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_duty();
    test_sweep();
    test_zero();
    test_gating();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
Parameters:
REQ-001 The module SHALL have parameter N, default 1: number of PWM channels.
REQ-002 The module SHALL have parameter R, default 4: duty/counter resolution in bits, giving a period of 2^R clocks.

Ports:
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 resets immediately, 1 runs.
REQ-005 The module SHALL have port in, input, N bits: per-channel enable; bit i gates channel i.
REQ-006 The module SHALL have port ds, input, R bits: duty setting shared by all channels; unsigned high-time in clocks per period.
REQ-007 The module SHALL have port out, output, N bits: registered PWM outputs, one per channel.

Function
REQ-008 The module SHALL contain one free-running R-bit period counter cnt that increments by 1 every clock and wraps from 2^R-1 to 0; it is never stalled or cleared except by reset.
REQ-009 The module SHALL contain an R-bit active-duty register dsa that captures ds on the clock edge where cnt == 2^R-1, so a new duty applies from the next cnt == 0.
REQ-010 A ds change mid-period SHALL NOT affect the current period, which guarantees glitch-free periods.
REQ-011 On each clock, out[i] SHALL be registered as in[i] AND (cnt < dsa), with cnt and dsa taken as the pre-edge values; this gives one clock of latency from the counter state.
REQ-012 Comparison SHALL be unsigned over R bits.
REQ-013 dsa = 0 SHALL give out constantly 0.
REQ-014 dsa = 2^R-1 SHALL give 2^R-1 high and 1 low clock per period; 100% duty is not representable.
REQ-015 The high phase SHALL start at cnt == 0 and be contiguous, so each period is high for dsa clocks, then low for 2^R - dsa clocks.
REQ-016 in[i] SHALL be sampled every clock, not per period: in[i] = 0 forces out[i] low on the next edge, and in[i] returning to 1 resumes out[i] in phase with the running counter.
REQ-017 All channels SHALL share cnt and dsa, so their outputs are phase-aligned.
REQ-018 ds and in SHALL be synchronous to clk; no internal synchronizers are required.

Reset
REQ-019 While reset = 0, the module SHALL asynchronously force cnt = 0, dsa = 0 and out = all zeros.
REQ-020 After reset is released, cnt SHALL count from 0 on the first rising edge.
REQ-021 dsa SHALL remain 0 until the first wrap, so the first period after reset is entirely low regardless of ds; ds is first applied 2^R clocks after release.
REQ-022 Reset asserted mid-period SHALL abort the period immediately: out = 0 without waiting for a clock edge.

Verification
REQ-023 Reset check: hold reset = 0 with in = 1 and ds = 4'b1111 -> out = 0, cnt = 0 and dsa = 0 throughout, including between clock edges.
REQ-024 Full duty: N = 1, R = 4, in = 1, ds = 4'b1111 -> first 16 clocks after release out = 0; then a repeating pattern of 15 clocks high and 1 low.
REQ-025 Duty sweep: hold each of ds = 4'b1000, 4'b0100, 4'b0010, 4'b0001 for at least 3 periods -> 8/16, 4/16, 2/16 and 1/16 high respectively; every change takes effect exactly at the next period boundary, with no partial period.
REQ-026 Zero duty: ds = 4'b0000 -> out stays 0 for all subsequent periods.
REQ-027 Enable gating: ds = 4'b1000 with in toggled 1 -> 0 -> 1 mid high phase -> out drops one clock after in falls; after in rises, out follows cnt < 8 from the next clock.
REQ-028 Mid-operation reset: assert reset = 0 during a high phase -> out falls asynchronously; after release, the first period is low and the original duty returns in the second period.
